// File: rtl/toom_8_evaluation_if.sv
// Handshake bundle between the operand splitter, the Toom-8 evaluator and the
// pointwise multipliers. The slave side is the evaluator.
interface toom_8_evaluation_if #(
    parameter int CW = 129,
    parameter int EW = 150
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*CW-1:0]      a_chunks;
    logic [8*CW-1:0]      b_chunks;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_idx;
    logic signed [EW-1:0] out_a;
    logic signed [EW-1:0] out_b;
    logic                 out_last;

    modport master (
        output in_valid, a_chunks, b_chunks, out_ready,
        input  in_ready, out_valid, out_idx, out_a, out_b, out_last
    );

    modport slave (
        input  in_valid, a_chunks, b_chunks, out_ready,
        output in_ready, out_valid, out_idx, out_a, out_b, out_last
    );
endinterface

// File: rtl/toom_8_evaluation.sv
// Toom-8 evaluation: latches one job of 2x8 chunks and streams both degree-7
// polynomials evaluated at the 15 Toom-8 points, one point pair per transfer.
module toom_8_evaluation #(
    parameter int CW   = 129,
    parameter int EW   = 150,
    parameter int NPTS = 15
) (
    input logic                clk,
    input logic                rst,
    toom_8_evaluation_if.slave bus
);
    localparam logic [3:0] LAST_IDX = 4'(NPTS - 1);

    typedef enum logic {IDLE, EVAL} state_t;

    state_t          state, state_nxt;
    logic [8*CW-1:0] a_coef_p0, b_coef_p0;
    logic [3:0]      idx_nxt;
    logic            accept, advance, finish;

    function automatic logic signed [EW-1:0] zext(input logic [CW-1:0] c);
        return signed'({{(EW-CW){1'b0}}, c});
    endfunction

    // idx 1,3,5.. map to +1,+2,+3..; idx 2,4,6.. map to -1,-2,-3..; idx 0 is 0
    function automatic logic signed [EW-1:0] point(input logic [3:0] idx);
        logic signed [EW-1:0] mag;
        mag      = '0;
        mag[3:0] = (idx + 4'd1) >> 1;
        return idx[0] ? mag : -mag;
    endfunction

    // Horner at full EW width; partial sums never exceed the final bound
    function automatic logic signed [EW-1:0] horner(input logic [8*CW-1:0] c,
                                                    input logic [3:0]      idx);
        logic signed [EW-1:0] acc, p;
        p   = point(idx);
        acc = zext(c[7*CW +: CW]);
        for (int i = 6; i >= 0; i--)
            acc = acc * p + zext(c[i*CW +: CW]);
        if (idx == LAST_IDX)
            acc = zext(c[7*CW +: CW]);
        return acc;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        advance       = 1'b0;
        finish        = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (bus.out_idx == LAST_IDX) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign idx_nxt = bus.out_idx + 4'd1;

    // Stage p0: coefficient capture at accept, one evaluated point pair per transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_coef_p0    <= '0;
            b_coef_p0    <= '0;
            bus.out_idx  <= '0;
            bus.out_a    <= '0;
            bus.out_b    <= '0;
            bus.out_last <= 1'b0;
        end else if (accept) begin
            a_coef_p0    <= bus.a_chunks;
            b_coef_p0    <= bus.b_chunks;
            bus.out_idx  <= '0;
            bus.out_a    <= zext(bus.a_chunks[CW-1:0]);
            bus.out_b    <= zext(bus.b_chunks[CW-1:0]);
            bus.out_last <= 1'b0;
        end else if (advance) begin
            bus.out_idx  <= idx_nxt;
            bus.out_a    <= horner(a_coef_p0, idx_nxt);
            bus.out_b    <= horner(b_coef_p0, idx_nxt);
            bus.out_last <= (idx_nxt == LAST_IDX);
        end else if (finish) begin
            bus.out_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_toom_8_evaluation.sv
// Randomized and directed bench for toom_8_evaluation against a power-sum model.
module tb_toom_8_evaluation;
    localparam int CW = 129;
    localparam int EW = 150;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    int pt [14] = '{0, 1, -1, 2, -2, 3, -3, 4, -4, 5, -5, 6, -6, 7};
    int ones_tab [15] = '{1, 8, 0, 255, -85, 3280, -1640, 21845, -13107,
                          97656, -65104, 335923, -239945, 960800, 1};

    logic signed [EW-1:0] spot_a [15];
    logic signed [EW-1:0] spot_b [15];
    bit                   spot_a_en [15];
    bit                   spot_b_en [15];

    toom_8_evaluation_if #(.CW(CW), .EW(EW)) bus ();

    toom_8_evaluation #(.CW(CW), .EW(EW), .NPTS(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [EW-1:0] obs,
                       input logic signed [EW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Reference: direct sum of c_i * p^i with explicit powers
    function automatic logic signed [EW-1:0] ref_val(input logic [8*CW-1:0] c, input int idx);
        logic signed [EW-1:0] sum, pw, p, ci;
        ci = '0;
        if (idx == 14) begin
            ci[CW-1:0] = c[7*CW +: CW];
            return ci;
        end
        sum = '0;
        pw  = 1;
        p   = pt[idx];
        for (int i = 0; i < 8; i++) begin
            ci         = '0;
            ci[CW-1:0] = c[i*CW +: CW];
            sum        = sum + ci * pw;
            pw         = pw * p;
        end
        return sum;
    endfunction

    function automatic logic [8*CW-1:0] rnd_vec();
        logic [8*CW-1:0] v;
        for (int j = 0; j < 8*CW; j++) v[j] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [8*CW-1:0] pack_each(input int k0, input int step);
        logic [8*CW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*CW +: CW] = CW'(k0 + step * i);
        return v;
    endfunction

    task automatic clear_spots();
        for (int i = 0; i < 15; i++) begin
            spot_a[i] = '0; spot_b[i] = '0; spot_a_en[i] = 0; spot_b_en[i] = 0;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " out_valid"}, bus.out_valid, 0);
        chk({tag, " in_ready"},  bus.in_ready, 1);
        chk({tag, " out_idx"},   bus.out_idx, 0);
        chk({tag, " out_a"},     bus.out_a, 0);
        chk({tag, " out_b"},     bus.out_b, 0);
        chk({tag, " out_last"},  bus.out_last, 0);
    endtask

    // Entry and exit: 1 time unit after a rising edge
    task automatic run_job(input logic [8*CW-1:0] a, input logic [8*CW-1:0] b,
                           input bit rnd_ready, input int stall_at, input int abort_at,
                           input bit chain, input logic [8*CW-1:0] na,
                           input logic [8*CW-1:0] nb);
        int exp_idx;
        int cyc;
        int stall_cnt;
        bit rdy;
        exp_idx   = 0;
        cyc       = 0;
        stall_cnt = 0;
        bus.in_valid  = 1'b1;
        bus.a_chunks  = a;
        bus.b_chunks  = b;
        bus.out_ready = 1'b0;
        chk("in_ready before accept", bus.in_ready, 1);
        @(posedge clk); #1;
        if (chain) begin
            bus.a_chunks = na;
            bus.b_chunks = nb;
        end else begin
            bus.in_valid = 1'b0;
            bus.a_chunks = rnd_vec();
            bus.b_chunks = rnd_vec();
        end
        while (exp_idx < 15 && cyc < 400) begin
            if (exp_idx == abort_at) begin
                bus.out_ready = 1'b1;
                rst = 1'b1;
                #1;
                chk_reset_state("async reset");
                #2;
                rst = 1'b0;
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                chk("post-reset out_valid", bus.out_valid, 0);
                chk("post-reset in_ready", bus.in_ready, 1);
                bus.out_ready = 1'b0;
                return;
            end
            chk($sformatf("out_valid idx%0d", exp_idx), bus.out_valid, 1);
            chk($sformatf("in_ready idx%0d", exp_idx), bus.in_ready, 0);
            chk($sformatf("out_idx idx%0d", exp_idx), bus.out_idx, exp_idx);
            chk($sformatf("out_last idx%0d", exp_idx), bus.out_last, (exp_idx == 14) ? 1 : 0);
            chk($sformatf("out_a idx%0d", exp_idx), bus.out_a, ref_val(a, exp_idx));
            chk($sformatf("out_b idx%0d", exp_idx), bus.out_b, ref_val(b, exp_idx));
            if (spot_a_en[exp_idx])
                chk($sformatf("const a idx%0d", exp_idx), bus.out_a, spot_a[exp_idx]);
            if (spot_b_en[exp_idx])
                chk($sformatf("const b idx%0d", exp_idx), bus.out_b, spot_b[exp_idx]);
            if (exp_idx == stall_at && stall_cnt < 5) begin
                rdy = 1'b0;
                stall_cnt++;
            end else if (rnd_ready) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            bus.out_ready = rdy;
            @(posedge clk); #1;
            if (rdy) exp_idx++;
            cyc++;
        end
        chk("beats per job", exp_idx, 15);
        bus.out_ready = 1'b0;
        chk("idle out_valid", bus.out_valid, 0);
        chk("idle in_ready", bus.in_ready, 1);
    endtask

    initial begin
        logic [8*CW-1:0]      ones, ramp, maxv, r1, r2, r3, r4;
        logic signed [EW-1:0] m;
        n_vec = 0;
        n_err = 0;
        clear_spots();

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_chunks  = '0;
        bus.b_chunks  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("no beat after reset", bus.out_valid, 0);

        ones = pack_each(1, 0);
        for (int i = 0; i < 15; i++) begin
            spot_a[i] = ones_tab[i]; spot_a_en[i] = 1;
            spot_b[i] = ones_tab[i]; spot_b_en[i] = 1;
        end
        run_job(ones, ones, 0, -1, -1, 0, '0, '0);

        clear_spots();
        ramp = pack_each(0, 1);
        spot_a[1] = 28; spot_a[2] = -4; spot_a[14] = 7;
        spot_a_en[1] = 1; spot_a_en[2] = 1; spot_a_en[14] = 1;
        run_job(ramp, '0, 0, -1, -1, 0, '0, '0);

        clear_spots();
        maxv = '1;
        m = '0;
        m[CW-1:0] = '1;
        spot_a[13] = m * 960800;
        spot_a[12] = -(m * 239945);
        spot_b[13] = spot_a[13];
        spot_b[12] = spot_a[12];
        spot_a_en[12] = 1; spot_a_en[13] = 1; spot_b_en[12] = 1; spot_b_en[13] = 1;
        run_job(maxv, maxv, 0, -1, -1, 0, '0, '0);

        clear_spots();
        r1 = rnd_vec(); r2 = rnd_vec();
        run_job(r1, r2, 1, 6, -1, 0, '0, '0);

        r1 = rnd_vec(); r2 = rnd_vec(); r3 = rnd_vec(); r4 = rnd_vec();
        run_job(r1, r2, 0, -1, -1, 1, r3, r4);
        run_job(r3, r4, 1, -1, -1, 0, '0, '0);

        r1 = rnd_vec(); r2 = rnd_vec();
        run_job(r1, r2, 0, -1, 9, 0, '0, '0);
        r1 = rnd_vec(); r2 = rnd_vec();
        run_job(r1, r2, 1, -1, -1, 0, '0, '0);

        for (int k = 0; k < 3; k++) begin
            r1 = rnd_vec(); r2 = rnd_vec();
            run_job(r1, r2, 1, -1, -1, 0, '0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
